// File: rtl/ray_face_scheduler.sv
// ray_face_scheduler
// -----------------------------------------------------------------------------
// Walks a list of faces for one ray and keeps the nearest hit. Each face is
// read from an external face memory and presented to an external
// combinational intersection datapath. The result comes back one cycle later,
// and the scheduler then applies a divide-by-zero guard, computes the
// Manhattan distance from the camera and keeps the nearest hit.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   start                        begin a scan (ignored while busy)
//   camera_location              ray origin, latched on an accepted start
//   directional_vector           ray direction, latched on an accepted start
//   face_count                   number of faces (clamped to MAX_FACES)
//   face_rd / face_addr          face-memory read request and index
//   face_valid                   face record valid for face_addr
//   face_normal, face_bottom_left, face_size   face record
//   isect_camera, isect_dir, isect_normal,
//   isect_bottom_left, isect_size              registered datapath operands
//   isect_location, isect_hit                  datapath result
//   busy, done                   scan in progress, one-cycle completion pulse
//   hit, hit_index, hit_location, hit_distance nearest-hit result
// -----------------------------------------------------------------------------
module ray_face_scheduler #(
  parameter int  W         = 12,
  parameter int  MAX_FACES = 64,
  localparam int AW        = $clog2(MAX_FACES)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [2:0][W-1:0]   camera_location,
  input  logic [2:0][W-1:0]   directional_vector,
  input  logic [AW:0]         face_count,
  output logic                face_rd,
  output logic [AW-1:0]       face_addr,
  input  logic                face_valid,
  input  logic [2:0][W-1:0]   face_normal,
  input  logic [2:0][W-1:0]   face_bottom_left,
  input  logic [1:0][W-1:0]   face_size,
  output logic [2:0][W-1:0]   isect_camera,
  output logic [2:0][W-1:0]   isect_dir,
  output logic [2:0][W-1:0]   isect_normal,
  output logic [2:0][W-1:0]   isect_bottom_left,
  output logic [1:0][W-1:0]   isect_size,
  input  logic [2:0][W-1:0]   isect_location,
  input  logic                isect_hit,
  output logic                busy,
  output logic                done,
  output logic                hit,
  output logic [AW-1:0]       hit_index,
  output logic [2:0][W-1:0]   hit_location,
  output logic [W+1:0]        hit_distance
);

  typedef enum logic [2:0] {IDLE, FETCH, EVAL, CMP, DONE} state_t;

  state_t        state_q;
  logic [AW:0]   faceCount_q;
  logic [AW:0]   faceCount_d;
  logic [W-1:0]  dirOnAxis_d;
  logic          candHit_d;
  logic [W+1:0]  candDist_d;
  logic          isLast_d;

  function automatic logic [W-1:0] absDiff(input logic [W-1:0] a, input logic [W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // Requested face count, clamped to the depth of the face list.
  always_comb begin
    faceCount_d = face_count;
    if (face_count > (AW+1)'(MAX_FACES)) begin
      faceCount_d = (AW+1)'(MAX_FACES);
    end
  end

  // Direction component along the face's normal axis. A zero here means the
  // datapath divided by zero, so its hit flag cannot be trusted.
  always_comb begin
    dirOnAxis_d = isect_dir[2];
    if (isect_normal[0] != '0) begin
      dirOnAxis_d = isect_dir[0];
    end else if (isect_normal[1] != '0) begin
      dirOnAxis_d = isect_dir[1];
    end
  end

  // The sum of three W-bit magnitudes fits in W+2 bits, so it cannot overflow.
  always_comb begin
    candHit_d  = isect_hit && (dirOnAxis_d != '0);
    candDist_d = (W+2)'(absDiff(isect_location[0], isect_camera[0]))
               + (W+2)'(absDiff(isect_location[1], isect_camera[1]))
               + (W+2)'(absDiff(isect_location[2], isect_camera[2]));
    isLast_d   = ({1'b0, face_addr} == (faceCount_q - (AW+1)'(1)));
  end

  // Scan FSM. All outputs are registered here. face_addr doubles as the scan
  // index. Because faces are visited in ascending order and only a strictly
  // shorter distance replaces the best, ties keep the lower index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= IDLE;
      faceCount_q       <= '0;
      face_rd           <= 1'b0;
      face_addr         <= '0;
      isect_camera      <= '0;
      isect_dir         <= '0;
      isect_normal      <= '0;
      isect_bottom_left <= '0;
      isect_size        <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      hit               <= 1'b0;
      hit_index         <= '0;
      hit_location      <= '0;
      hit_distance      <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            isect_camera <= camera_location;
            isect_dir    <= directional_vector;
            faceCount_q  <= faceCount_d;
            hit          <= 1'b0;
            hit_index    <= '0;
            hit_location <= '0;
            hit_distance <= '0;
            face_addr    <= '0;
            busy         <= 1'b1;
            if (faceCount_d == '0) begin
              state_q <= DONE;
              done    <= 1'b1;
            end else begin
              state_q <= FETCH;
              face_rd <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (face_valid) begin
            isect_normal      <= face_normal;
            isect_bottom_left <= face_bottom_left;
            isect_size        <= face_size;
            face_rd           <= 1'b0;
            state_q           <= EVAL;
          end
        end
        EVAL: begin
          state_q <= CMP;
        end
        CMP: begin
          if (candHit_d && (!hit || (candDist_d < hit_distance))) begin
            hit          <= 1'b1;
            hit_index    <= face_addr;
            hit_location <= isect_location;
            hit_distance <= candDist_d;
          end
          if (isLast_d) begin
            state_q <= DONE;
            done    <= 1'b1;
          end else begin
            face_addr <= face_addr + AW'(1);
            face_rd   <= 1'b1;
            state_q   <= FETCH;
          end
        end
        DONE: begin
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ray_face_scheduler.sv
// tb_ray_face_scheduler
// -----------------------------------------------------------------------------
// Self-checking bench for ray_face_scheduler. The bench plays both the face
// memory (tables indexed by face_addr, with a per-face valid delay) and the
// intersection datapath (the reported location is the face's bottom-left
// corner, and a face reports a hit when its size is non-zero). A reference
// model walks the same tables to predict the nearest hit and the done cycle.
// -----------------------------------------------------------------------------
module tb_ray_face_scheduler;

  localparam int W    = 12;
  localparam int MAXF = 8;
  localparam int AW   = 3;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic [2:0][W-1:0]   camera_location = '0;
  logic [2:0][W-1:0]   directional_vector = '0;
  logic [AW:0]         face_count = '0;
  logic                face_rd;
  logic [AW-1:0]       face_addr;
  logic                face_valid;
  logic [2:0][W-1:0]   face_normal;
  logic [2:0][W-1:0]   face_bottom_left;
  logic [1:0][W-1:0]   face_size;
  logic [2:0][W-1:0]   isect_camera;
  logic [2:0][W-1:0]   isect_dir;
  logic [2:0][W-1:0]   isect_normal;
  logic [2:0][W-1:0]   isect_bottom_left;
  logic [1:0][W-1:0]   isect_size;
  logic [2:0][W-1:0]   isect_location;
  logic                isect_hit;
  logic                busy;
  logic                done;
  logic                hit;
  logic [AW-1:0]       hit_index;
  logic [2:0][W-1:0]   hit_location;
  logic [W+1:0]        hit_distance;

  logic [2:0][W-1:0]   faceNormalTab [MAXF];
  logic [2:0][W-1:0]   faceBlTab     [MAXF];
  logic [1:0][W-1:0]   faceSizeTab   [MAXF];
  int                  delayTab      [MAXF];
  bit                  forceHit = 1'b0;
  int                  fetchWait;
  int                  rdCount = 0;
  int                  checks = 0;
  int                  fails = 0;

  ray_face_scheduler #(.W(W), .MAX_FACES(MAXF)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .camera_location(camera_location), .directional_vector(directional_vector),
    .face_count(face_count), .face_rd(face_rd), .face_addr(face_addr),
    .face_valid(face_valid), .face_normal(face_normal),
    .face_bottom_left(face_bottom_left), .face_size(face_size),
    .isect_camera(isect_camera), .isect_dir(isect_dir),
    .isect_normal(isect_normal), .isect_bottom_left(isect_bottom_left),
    .isect_size(isect_size), .isect_location(isect_location),
    .isect_hit(isect_hit), .busy(busy), .done(done), .hit(hit),
    .hit_index(hit_index), .hit_location(hit_location),
    .hit_distance(hit_distance)
  );

  always #5 clk = ~clk;

  // Face memory: the record is available combinationally, but valid is held
  // off for delayTab[addr] cycles of each read request.
  assign face_normal      = faceNormalTab[face_addr];
  assign face_bottom_left = faceBlTab[face_addr];
  assign face_size        = faceSizeTab[face_addr];
  assign face_valid       = face_rd && (fetchWait >= delayTab[face_addr]);

  // Intersection datapath stand-in driven purely from the operand outputs.
  assign isect_location = isect_bottom_left;
  assign isect_hit      = (isect_size[0] != '0) || forceHit;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) fetchWait <= 0;
    else if (!face_rd) fetchWait <= 0;
    else fetchWait <= fetchWait + 1;
  end

  always @(posedge clk) begin
    if (face_rd) rdCount <= rdCount + 1;
  end

  function automatic logic [2:0][W-1:0] vec3(input int x, input int y, input int z);
    return {W'(z), W'(y), W'(x)};
  endfunction

  function automatic int rnd();
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4095)) : int'($urandom_range(0, 15));
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      fails++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".face_rd"}, face_rd, 0);
    checkOutput({tag, ".face_addr"}, face_addr, 0);
    checkOutput({tag, ".isect_camera"}, isect_camera, 0);
    checkOutput({tag, ".isect_dir"}, isect_dir, 0);
    checkOutput({tag, ".isect_normal"}, isect_normal, 0);
    checkOutput({tag, ".isect_bl"}, isect_bottom_left, 0);
    checkOutput({tag, ".isect_size"}, isect_size, 0);
    checkOutput({tag, ".busy"}, busy, 0);
    checkOutput({tag, ".done"}, done, 0);
    checkOutput({tag, ".hit"}, hit, 0);
    checkOutput({tag, ".hit_index"}, hit_index, 0);
    checkOutput({tag, ".hit_location"}, hit_location, 0);
    checkOutput({tag, ".hit_distance"}, hit_distance, 0);
  endtask

  // Nearest-hit reference: walk the face tables in order, applying the
  // normal-axis guard and the Manhattan distance, keeping the strictly
  // smallest distance. Also predicts the done cycle from the valid delays.
  task automatic modelScan(input logic [2:0][W-1:0] cam, input logic [2:0][W-1:0] dir,
                           input int fc, output bit expHit, output int expIdx,
                           output logic [2:0][W-1:0] expLoc, output int expDist,
                           output int expCycles);
    int n;
    int ax;
    int d;
    bit isHit;
    n = (fc > MAXF) ? MAXF : fc;
    expHit = 0; expIdx = 0; expLoc = '0; expDist = 0; expCycles = 1;
    for (int i = 0; i < n; i++) begin
      expCycles += 3 + delayTab[i];
      if (faceNormalTab[i][0] != 0) ax = 0;
      else if (faceNormalTab[i][1] != 0) ax = 1;
      else ax = 2;
      isHit = ((faceSizeTab[i][0] != 0) || forceHit) && (dir[ax] != 0);
      d = 0;
      for (int k = 0; k < 3; k++) begin
        if (int'(faceBlTab[i][k]) >= int'(cam[k])) d += int'(faceBlTab[i][k]) - int'(cam[k]);
        else d += int'(cam[k]) - int'(faceBlTab[i][k]);
      end
      if (isHit && (!expHit || d < expDist)) begin
        expHit = 1; expIdx = i; expLoc = faceBlTab[i]; expDist = d;
      end
    end
  endtask

  // Runs one scan from IDLE and checks result, timing and post-done hold.
  // pokeStart raises start (with different operands) while the scan is busy.
  task automatic applyStimulus(input string tag, input logic [2:0][W-1:0] cam,
                               input logic [2:0][W-1:0] dir, input int fc,
                               input bit pokeStart);
    bit expHit;
    int expIdx;
    logic [2:0][W-1:0] expLoc;
    int expDist;
    int expCycles;
    int cyc;
    int rdBefore;
    bit gotDone;
    modelScan(cam, dir, fc, expHit, expIdx, expLoc, expDist, expCycles);
    @(negedge clk);
    camera_location = cam;
    directional_vector = dir;
    face_count = (AW+1)'(fc);
    start = 1'b1;
    rdBefore = rdCount;
    cyc = 0;
    gotDone = 0;
    while (cyc < 400 && !gotDone) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) start = 1'b0;
      if (pokeStart && cyc == 2) begin
        start = 1'b1;
        face_count = (AW+1)'(1);
        camera_location = vec3(99, 99, 99);
        directional_vector = vec3(7, 7, 7);
      end
      if (cyc == 3) start = 1'b0;
      if (done) gotDone = 1;
    end
    start = 1'b0;
    checkOutput({tag, ".doneSeen"}, gotDone, 1);
    checkOutput({tag, ".doneCycle"}, cyc, expCycles);
    checkOutput({tag, ".busyAtDone"}, busy, 1);
    checkOutput({tag, ".hit"}, hit, expHit);
    checkOutput({tag, ".hit_index"}, hit_index, expIdx);
    checkOutput({tag, ".hit_location"}, hit_location, expLoc);
    checkOutput({tag, ".hit_distance"}, hit_distance, expDist);
    checkOutput({tag, ".isect_camera"}, isect_camera, cam);
    checkOutput({tag, ".isect_dir"}, isect_dir, dir);
    if (fc == 0) checkOutput({tag, ".noFaceRead"}, rdCount - rdBefore, 0);
    @(negedge clk);
    checkOutput({tag, ".donePulse"}, done, 0);
    checkOutput({tag, ".busyAfter"}, busy, 0);
    checkOutput({tag, ".holdHit"}, hit, expHit);
    checkOutput({tag, ".holdIndex"}, hit_index, expIdx);
    checkOutput({tag, ".holdDistance"}, hit_distance, expDist);
  endtask

  task automatic setFace(input int i, input logic [2:0][W-1:0] nrm,
                         input logic [2:0][W-1:0] bl, input int sz, input int dly);
    faceNormalTab[i] = nrm;
    faceBlTab[i] = bl;
    faceSizeTab[i] = {W'(sz), W'(sz)};
    delayTab[i] = dly;
  endtask

  initial begin
    int cyc;
    bit sawDone;
    for (int i = 0; i < MAXF; i++) setFace(i, vec3(1, 0, 0), vec3(0, 0, 0), 0, 0);

    // Reset state
    #12;
    checkAllZero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Two x-normal faces, nearer one at index 1
    setFace(0, vec3(1, 0, 0), vec3(8, 4, 2), 1, 0);
    setFace(1, vec3(1, 0, 0), vec3(4, 2, 1), 1, 0);
    applyStimulus("basic", vec3(0, 0, 0), vec3(4, 2, 1), 2, 0);
    checkOutput("basic.litIndex", hit_index, 1);
    checkOutput("basic.litDistance", hit_distance, 7);

    // Empty face list
    applyStimulus("empty", vec3(3, 3, 3), vec3(1, 1, 1), 0, 0);
    checkOutput("empty.litHit", hit, 0);

    // Divide-by-zero guard: z normal with zero z direction, forced datapath hit
    setFace(0, vec3(0, 0, 5), vec3(2, 2, 2), 0, 0);
    forceHit = 1'b1;
    applyStimulus("guard", vec3(0, 0, 0), vec3(3, 5, 0), 1, 0);
    checkOutput("guard.litHit", hit, 0);
    forceHit = 1'b0;

    // Equal distances keep the lower index, with and without valid delay
    setFace(0, vec3(1, 0, 0), vec3(5, 3, 2), 1, 0);
    setFace(1, vec3(0, 1, 0), vec3(2, 3, 5), 1, 0);
    applyStimulus("tie", vec3(0, 0, 0), vec3(1, 1, 1), 2, 0);
    checkOutput("tie.litIndex", hit_index, 0);
    checkOutput("tie.litDistance", hit_distance, 10);
    delayTab[0] = 3;
    delayTab[1] = 3;
    applyStimulus("tieDelayed", vec3(0, 0, 0), vec3(1, 1, 1), 2, 0);
    checkOutput("tieDelayed.litIndex", hit_index, 0);

    // Start pulsed while busy must be ignored
    setFace(0, vec3(1, 0, 0), vec3(9, 1, 1), 1, 0);
    setFace(1, vec3(0, 1, 0), vec3(3, 6, 1), 1, 1);
    setFace(2, vec3(0, 0, 1), vec3(1, 1, 4), 1, 0);
    applyStimulus("busyStart", vec3(1, 1, 1), vec3(2, 2, 2), 3, 1);

    // Reset during EVAL of the second of four faces
    for (int i = 0; i < 4; i++) setFace(i, vec3(1, 0, 0), vec3(i + 2, 1, 1), 1, 0);
    @(negedge clk);
    camera_location = vec3(1, 1, 1);
    directional_vector = vec3(1, 1, 1);
    face_count = 4'd4;
    start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    checkOutput("abort.busyBefore", busy, 1);
    checkOutput("abort.addrBefore", face_addr, 1);
    rst_n = 1'b0;
    #1;
    checkAllZero("abort");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sawDone = 0;
    cyc = 0;
    while (cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (done) sawDone = 1;
    end
    checkOutput("abort.noDone", sawDone, 0);
    setFace(0, vec3(0, 1, 0), vec3(6, 4, 3), 1, 0);
    applyStimulus("afterAbort", vec3(1, 1, 1), vec3(2, 3, 1), 1, 0);

    // Randomized scans, including counts above the face-list depth
    for (int t = 0; t < 25; t++) begin
      logic [2:0][W-1:0] cam;
      logic [2:0][W-1:0] dir;
      for (int i = 0; i < MAXF; i++) begin
        setFace(i, vec3($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1)),
                vec3(rnd(), rnd(), rnd()), ($urandom_range(0, 4) == 0) ? 0 : 1,
                $urandom_range(0, 3));
      end
      cam = vec3(rnd(), rnd(), rnd());
      dir = vec3(($urandom_range(0, 3) == 0) ? 0 : rnd(),
                 ($urandom_range(0, 3) == 0) ? 0 : rnd(),
                 ($urandom_range(0, 3) == 0) ? 0 : rnd());
      applyStimulus($sformatf("rand%0d", t), cam, dir, $urandom_range(0, 11),
                    bit'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/ray_face_scheduler.md
RAY_FACE_SCHEDULER -- requirements
Module: ray_face_scheduler

Interface
- REQ-001 Parameter: W, default 12, width of each coordinate/vector component.
- REQ-002 Parameter: MAX_FACES, default 64, face-list depth; AW = clog2(MAX_FACES).
- REQ-003 Ports, in order (name, direction, width, meaning):
  - clk  in  1  single clock, all state on rising edge.
  - rst_n  in  1  asynchronous, active-low reset.
  - start  in  1  begin one ray scan; ignored while busy.
  - camera_location  in  [2:0][W-1:0]  ray origin, sampled on accepted start.
  - directional_vector  in  [2:0][W-1:0]  ray direction, sampled on accepted start.
  - face_count  in  AW+1  number of faces to scan (0..MAX_FACES), sampled on accepted start.
  - face_rd  out  1  face-memory read request.
  - face_addr  out  AW  face index being read.
  - face_valid  in  1  face data valid for current face_addr.
  - face_normal, face_bottom_left  in  [2:0][W-1:0]  face record.
  - face_size  in  [1:0][W-1:0]  face extent.
  - isect_camera, isect_dir, isect_normal, isect_bottom_left  out  [2:0][W-1:0]  operands to the combinational intersection datapath.
  - isect_size  out  [1:0][W-1:0]  operand to the datapath.
  - isect_location  in  [2:0][W-1:0]  datapath result.
  - isect_hit  in  1  datapath intersect flag.
  - busy  out  1  scan in progress.
  - done  out  1  one-cycle completion pulse.
  - hit  out  1  at least one face hit.
  - hit_index  out  AW  index of nearest hit face.
  - hit_location  out  [2:0][W-1:0]  location of nearest hit.
  - hit_distance  out  W+2  Manhattan distance of nearest hit.

Function
- REQ-004 The FSM SHALL have states IDLE, FETCH, EVAL, CMP, DONE.
- REQ-005 IDLE: start=1 SHALL latch camera, direction and face_count, clear the best-hit registers, set idx=0, and go to FETCH; if face_count=0, go to DONE instead.
- REQ-006 FETCH: face_rd=1, face_addr=idx; the state holds until face_valid=1, then SHALL register the face record into the isect_* operand registers and go to EVAL.
- REQ-007 EVAL: the operands SHALL be held stable for one full cycle, allowing the datapath to settle; next state CMP.
- REQ-008 CMP: sample isect_hit and isect_location.
  - If the face counts as a hit and its distance is strictly less than the best distance (or no best exists yet), update hit, hit_index, hit_location and hit_distance.
  - Then, if idx = face_count-1, go to DONE; otherwise idx++ and go to FETCH.
- REQ-009 Normal axis SHALL be x if normal[0]≠0, else y if normal[1]≠0, else z.
- REQ-010 If the latched direction component on the normal axis is 0, the face SHALL be treated as a miss regardless of isect_hit (divide-by-zero guard).
- REQ-011 Distance = |lx-cx|+|ly-cy|+|lz-cz|, computed on W-bit unsigned operands, zero-extended to W+2 bits, no overflow.
- REQ-012 Ties on distance SHALL keep the lower index.
- REQ-013 DONE: done=1 for exactly one cycle, busy=0 afterwards, return to IDLE.
- REQ-014 busy SHALL be 1 in FETCH, EVAL, CMP and DONE, and 0 in IDLE.
- REQ-015 Timing with face_valid tied high (same-cycle valid):
  - Each face costs 3 cycles.
  - done SHALL assert 3N+1 cycles after the cycle in which start is accepted (N=face_count).
  - For N=0, done SHALL assert 1 cycle after start is accepted.
- REQ-016 hit, hit_index, hit_location and hit_distance SHALL stay stable from done until the next accepted start.
- REQ-017 start while busy=1 SHALL be ignored, with no effect on the scan or outputs; start held high in IDLE SHALL begin a new scan every completion.
- REQ-018 face_count > MAX_FACES SHALL be clamped to MAX_FACES.

Reset
- REQ-019 rst_n=0 SHALL asynchronously force IDLE and set every output to 0 (face_rd, face_addr, isect_*, busy, done, hit, hit_index, hit_location, hit_distance).
- REQ-020 Reset mid-scan SHALL abort with no done pulse; the first start after release SHALL begin a clean scan.

Verification
- REQ-021 Bench SHALL cover these directed scenarios:
  - Camera (0,0,0), dir (4,2,1); faces 0: normal x at x=8, 1: normal x at x=4, both hit; face_valid high → done at cycle 7, hit=1, hit_index=1, hit_location=(4,2,1), hit_distance=7.
  - face_count=0, start → done 1 cycle later, hit=0, hit_index=0, face_rd never asserted.
  - One face, normal z, dir z component 0, datapath forced isect_hit=1 → hit=0 (guard).
  - Two faces returning equal distance 10 → hit_index=0; face_valid delayed 3 cycles per face → done at cycle 13, results unchanged.
  - rst_n pulsed low during EVAL of face 2 of 4 → all outputs 0 immediately, no done; a following start with 1 hitting face → done at cycle 4 with correct result.
  - start pulsed during busy → ignored; scan completes with the original face_count and correct done timing.
